imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, packs little-endian bytes into 32-bit instruction words, and issues one write per word to the IMEM write port at sequential word addresses. A trailing XOR checksum validates the stream. The block holds the CPU in reset via `cpu_hold` until a load completes successfully.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_word_packer.sv | 29 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader and IMEM.
package imem_pkg;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned WORD_BITS       = 8 * BYTES_PER_WORD;
  localparam int unsigned IMEM_DEPTH      = 256;
  localparam int unsigned IMEM_ADDR_WIDTH = 8;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian stream bytes into one instruction word; the first byte
// of each group lands in bits 7:0.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [7:0]           byte_in,
  output logic [WORD_BITS-1:0] word,
  output logic [1:0]           byte_cnt,
  output logic                 word_full
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word      <= '0;
      byte_cnt  <= '0;
      word_full <= 1'b0;
    end else if (shift_en) begin
      // Shift right so that after four bytes the oldest sits in the low lane.
      word      <= {byte_in, word[WORD_BITS-1:8]};
      byte_cnt  <= byte_cnt + 2'd1;
      word_full <= (byte_cnt == LAST_BYTE);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: header, little-endian word packing, sequential
// writes and trailing XOR checksum; holds the CPU until a good load.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_WIDTH_LENGTH = 32,
  parameter int MEM_DEPTH        = IMEM_DEPTH,
  parameter int ADDR_WIDTH       = IMEM_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [MEM_WIDTH_LENGTH-1:0] mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        cpu_hold
);

  localparam logic [15:0] DEPTH_W = 16'(MEM_DEPTH);

  state_t                 state;
  logic [15:0]            len;
  logic [ADDR_WIDTH:0]    word_cnt;
  logic [7:0]             xsum;

  logic                   xfer;
  logic                   idle_like;
  logic                   pk_clr;
  logic                   pk_shift;
  logic [WORD_BITS-1:0]   pk_word;
  logic [1:0]             pk_cnt;
  logic                   pk_full;
  logic [15:0]            len_hdr;
  logic [15:0]            cnt_next;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign xfer      = byte_valid && byte_ready;
  assign pk_clr    = idle_like && start;
  assign pk_shift  = xfer && (state == S_DATA);
  assign len_hdr   = {byte_in, len[7:0]};
  assign cnt_next  = 16'(word_cnt) + 16'd1;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift_en (pk_shift),
    .byte_in  (byte_in),
    .word     (pk_word),
    .byte_cnt (pk_cnt),
    .word_full(pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      word_cnt <= '0;
      xsum     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_LO;
            len      <= '0;
            word_cnt <= '0;
            xsum     <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= byte_in;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= byte_in;
            if (len_hdr > DEPTH_W)      state <= S_ERR;
            else if (len_hdr == 16'd0)  state <= S_CHK;
            else                        state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            xsum <= xsum ^ byte_in;
            // Leave on the 4th byte itself so the write lands one cycle later.
            if (pk_cnt == LAST_BYTE) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          state    <= (cnt_next == len) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (xfer) state <= (byte_in == xsum) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                 (state == S_DATA)   || (state == S_CHK);
    busy       = !idle_like;
    done       = (state == S_DONE);
    error      = (state == S_ERR);
    cpu_hold   = (state != S_DONE);
    mem_we     = (state == S_WRITE) && pk_full;
    mem_addr   = word_cnt[ADDR_WIDTH-1:0];
    mem_wdata  = pk_word;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, packing, checksum outcome,
// oversize header, zero length, full depth and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  st;

  int checks = 0;
  int failures = 0;
  int gap_max = 0;

  int          wr_count = 0;
  logic [7:0]  wr_addr [0:511];
  logic [31:0] wr_data [0:511];

  always #5 clk = ~clk;

  imem_loader #(.MEM_WIDTH_LENGTH(32), .MEM_DEPTH(256), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  assign st = {byte_ready, mem_we, busy, done, error, cpu_hold};

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_count < 512) begin
        wr_addr[wr_count] = mem_addr;
        wr_data[wr_count] = mem_wdata;
      end
      wr_count = wr_count + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL handshake byte=%02h got=no_ready exp=ready", b);
    end
  endtask

  task automatic send_good_len2(input logic [7:0] chk);
    logic [7:0] s [0:10];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, chk};
    for (int i = 0; i < 11; i++) send_byte(s[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (st !== 6'b000001) begin
      failures++; $display("FAIL reset_status got=%b exp=000001", st);
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_mem got=%h/%h exp=00/00000000", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_load();
    wr_count = 0;
    pulse_start();
    checks++;
    if (st !== 6'b101001) begin
      failures++; $display("FAIL start_ready got=%b exp=101001", st);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (st !== 6'b011001 || mem_addr !== 8'h00 || mem_wdata !== 32'h00000013) begin
      failures++;
      $display("FAIL write0_timing got=%b/%h/%h exp=011001/00/00000013", st, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (st !== 6'b101001) begin
      failures++; $display("FAIL write0_one_cycle got=%b exp=101001", st);
    end
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h90);
    checks++;
    if (st !== 6'b000100) begin
      failures++; $display("FAIL good_done got=%b exp=000100", st);
    end
    checks++;
    if (wr_count !== 2 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00000013 ||
        wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL good_writes got=%0d %h:%h %h:%h exp=2 00:00000013 01:00100093",
               wr_count, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_bad_checksum();
    wr_count = 0;
    pulse_start();
    send_good_len2(8'h91);
    checks++;
    if (st !== 6'b000011) begin
      failures++; $display("FAIL bad_chk_status got=%b exp=000011", st);
    end
    checks++;
    if (wr_count !== 2 || wr_data[0] !== 32'h00000013 || wr_data[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL bad_chk_writes got=%0d %h %h exp=2 00000013 00100093",
               wr_count, wr_data[0], wr_data[1]);
    end
  endtask

  task automatic test_len_too_big();
    wr_count = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    checks++;
    if (st !== 6'b000011) begin
      failures++; $display("FAIL oversize_status got=%b exp=000011", st);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_count !== 0 || st !== 6'b000011) begin
      failures++; $display("FAIL oversize_hold got=%0d/%b exp=0/000011", wr_count, st);
    end
  endtask

  task automatic test_len_zero_then_reload();
    wr_count = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (st !== 6'b000100 || wr_count !== 0) begin
      failures++; $display("FAIL len_zero got=%b/%0d exp=000100/0", st, wr_count);
    end
    pulse_start();
    checks++;
    if (st !== 6'b101001) begin
      failures++; $display("FAIL restart_from_done got=%b exp=101001", st);
    end
    send_good_len2(8'h90);
    checks++;
    if (st !== 6'b000100 || wr_count !== 2 || wr_data[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL reload got=%b/%0d/%h exp=000100/2/00100093", st, wr_count, wr_data[1]);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] x;
    logic [7:0] b0, b1, b2, b3;
    int bad;
    gap_max = 0;
    wr_count = 0;
    x = 8'h00;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i); b1 = 8'(i) ^ 8'h5A; b2 = ~8'(i); b3 = 8'(i * 7);
      x = x ^ b0 ^ b1 ^ b2 ^ b3;
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    end
    send_byte(x);
    checks++;
    if (st !== 6'b000100 || wr_count !== 256) begin
      failures++; $display("FAIL full_depth_done got=%b/%0d exp=000100/256", st, wr_count);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i); b1 = 8'(i) ^ 8'h5A; b2 = ~8'(i); b3 = 8'(i * 7);
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {b3, b2, b1, b0}) bad++;
    end
    checks++;
    if (bad != 0 || wr_addr[255] !== 8'hFF) begin
      failures++; $display("FAIL full_depth_data got=%0d_bad last_addr=%h exp=0_bad ff", bad, wr_addr[255]);
    end
  endtask

  task automatic test_reset_midload();
    gap_max = 3;
    wr_count = 0;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (st !== 6'b000001) begin
      failures++; $display("FAIL midload_reset got=%b exp=000001", st);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_count !== 0 || st !== 6'b000001) begin
      failures++; $display("FAIL midload_no_write got=%0d/%b exp=0/000001", wr_count, st);
    end
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h78);
    pulse_start();
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h08);
    checks++;
    if (st !== 6'b000100 || wr_count !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h12345678) begin
      failures++;
      $display("FAIL after_reset_load got=%b/%0d/%h/%h exp=000100/1/00/12345678",
               st, wr_count, wr_addr[0], wr_data[0]);
    end
    gap_max = 0;
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_len_too_big();
    test_len_zero_then_reload();
    test_full_depth();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
